// File: rtl/insn_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue: entry layout,
// predecode bits, RV32 major opcodes and the predecode helper.
package insn_queue_pkg;

    typedef enum logic [4:0] {
        OP_LOAD   = 5'b00000,
        OP_OP_IMM = 5'b00100,
        OP_STORE  = 5'b01000,
        OP_OP     = 5'b01100,
        OP_BRANCH = 5'b11000,
        OP_JALR   = 5'b11001,
        OP_JAL    = 5'b11011
    } opcode_t;

    typedef struct packed {
        logic        exc;
        logic [31:2] pc;
        logic        specid;
        logic [31:0] insn;
    } iq_entry_t;

    typedef struct packed {
        logic is_branch;
        logic is_jump;
        logic is_jalr;
    } iq_pd_t;

    // Compressed encodings (insn[1:0] != 11) never predecode as control flow.
    function automatic iq_pd_t predecode(input logic [31:0] insn);
        iq_pd_t  pd;
        opcode_t op;
        pd = '0;
        op = opcode_t'(insn[6:2]);
        if (insn[1:0] == 2'b11) begin
            pd.is_branch = (op == OP_BRANCH);
            pd.is_jump   = (op == OP_JAL) || (op == OP_JALR);
            pd.is_jalr   = (op == OP_JALR);
        end
        return pd;
    endfunction

endpackage

// File: rtl/insn_queue.sv
// Circular instruction queue between fetch1 and decode with kill and per-specid
// squash. Define INSN_QUEUE_PREDECODE_EN to store predecode bits per entry.
module insn_queue
    import insn_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_core,
    input  logic             reset,
    input  logic             fe1_valid,
    output logic             iq_stall,
    input  logic             fe1_exc,
    input  logic [31:2]      fe1_pc,
    input  logic             fe1_specid,
    input  logic [31:0]      fe1_insn,
    output logic             iq_valid,
    input  logic             de_stall,
    output logic             iq_exc,
    output logic [31:2]      iq_pc,
    output logic             iq_specid,
    output logic [31:0]      iq_insn,
    output logic [2:0]       iq_pd,
    input  logic             kill,
    input  logic             flush_spec,
    input  logic             flush_specid,
    output logic [CNT_W-1:0] iq_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [DEPTH-1:0] live;
    iq_entry_t        mem [DEPTH];
    logic             enq;
    logic             deq;

    // Stall looks only at the registered count so fetch1 never sees a
    // combinational path from decode.
    always_comb begin
        iq_stall = (iq_count == CNT_W'(DEPTH));
        iq_valid = (iq_count != '0) && live[head];
        enq      = fe1_valid && !iq_stall && !kill &&
                   !(flush_spec && (fe1_specid == flush_specid));
        deq      = (iq_count != '0) && (!iq_valid || !de_stall);
    end

    assign iq_exc    = mem[head].exc;
    assign iq_pc     = mem[head].pc;
    assign iq_specid = mem[head].specid;
    assign iq_insn   = mem[head].insn;

    always_ff @(posedge clk_core) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            iq_count <= '0;
            live     <= '0;
        end else if (kill) begin
            head     <= '0;
            tail     <= '0;
            iq_count <= '0;
            live     <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            iq_count <= iq_count + CNT_W'(enq) - CNT_W'(deq);
            // Squashed entries stay allocated and drain as dead heads.
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_spec && (mem[i].specid == flush_specid)) live[i] <= 1'b0;
            end
            if (enq) live[tail] <= 1'b1;
        end
    end

    always_ff @(posedge clk_core) begin
        if (enq) mem[tail] <= '{exc: fe1_exc, pc: fe1_pc, specid: fe1_specid, insn: fe1_insn};
    end

`ifdef INSN_QUEUE_PREDECODE_EN
    iq_pd_t pd_mem [DEPTH];

    always_ff @(posedge clk_core) begin
        if (enq) pd_mem[tail] <= predecode(fe1_insn);
    end

    assign iq_pd = pd_mem[head];
`else
    assign iq_pd = 3'b000;
`endif

endmodule

// File: tb/tb_insn_queue.sv
// Directed bench for insn_queue (DEPTH=4): vector table for fill/stream/wrap,
// hand sequences for flush, kill, reset dominance and predecode.
module tb_insn_queue;

    logic        clk_core = 1'b0;
    logic        reset;
    logic        fe1_valid;
    logic        iq_stall;
    logic        fe1_exc;
    logic [31:2] fe1_pc;
    logic        fe1_specid;
    logic [31:0] fe1_insn;
    logic        iq_valid;
    logic        de_stall;
    logic        iq_exc;
    logic [31:2] iq_pc;
    logic        iq_specid;
    logic [31:0] iq_insn;
    logic [2:0]  iq_pd;
    logic        kill;
    logic        flush_spec;
    logic        flush_specid;
    logic [2:0]  iq_count;

    int passed = 0;
    int total  = 0;

    insn_queue #(.DEPTH(4)) dut (
        .clk_core(clk_core), .reset(reset), .fe1_valid(fe1_valid), .iq_stall(iq_stall),
        .fe1_exc(fe1_exc), .fe1_pc(fe1_pc), .fe1_specid(fe1_specid), .fe1_insn(fe1_insn),
        .iq_valid(iq_valid), .de_stall(de_stall), .iq_exc(iq_exc), .iq_pc(iq_pc),
        .iq_specid(iq_specid), .iq_insn(iq_insn), .iq_pd(iq_pd), .kill(kill),
        .flush_spec(flush_spec), .flush_specid(flush_specid), .iq_count(iq_count)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic        fv, ds, kl, fs, fsid, fid;
        logic [29:0] pc;
        logic [2:0]  e_cnt;
        logic        e_val, e_stall;
        logic [29:0] e_pc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic fv, ds, kl, fs, fsid, fid,
                         input logic [29:0] pc, input logic [31:0] insn);
        fe1_valid = fv; de_stall = ds; kill = kl; flush_spec = fs;
        flush_specid = fsid; fe1_specid = fid; fe1_pc = pc; fe1_insn = insn;
        fe1_exc = pc[0];
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 1, 0, 0, 0, 0, '0, '0);
        tick(); tick();
        reset = 1'b0;
    endtask

    vec_t vecs [14];
    logic [2:0] exp_pd [4];
    logic [31:0] pd_insn [4];

    initial begin
        reset = 1'b1;
        drive(0, 1, 0, 0, 0, 0, '0, '0);
        do_reset();
        chk("reset_count", 32'(iq_count), 0);
        chk("reset_valid", 32'(iq_valid), 0);
        chk("reset_stall", 32'(iq_stall), 0);

        //            fv ds kl fs fsid fid pc     cnt val stl e_pc
        vecs[0]  = '{1, 1, 0, 0, 0, 0, 30'h10, 1, 1, 0, 30'h10};
        vecs[1]  = '{1, 1, 0, 0, 0, 0, 30'h11, 2, 1, 0, 30'h10};
        vecs[2]  = '{1, 1, 0, 0, 0, 0, 30'h12, 3, 1, 0, 30'h10};
        vecs[3]  = '{1, 1, 0, 0, 0, 0, 30'h13, 4, 1, 1, 30'h10};
        vecs[4]  = '{1, 1, 0, 0, 0, 0, 30'h14, 4, 1, 1, 30'h10};
        vecs[5]  = '{1, 0, 0, 0, 0, 0, 30'h14, 3, 1, 0, 30'h11};
        vecs[6]  = '{1, 0, 0, 0, 0, 0, 30'h14, 3, 1, 0, 30'h12};
        vecs[7]  = '{1, 0, 0, 0, 0, 0, 30'h15, 3, 1, 0, 30'h13};
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 30'h16, 3, 1, 0, 30'h14};
        vecs[9]  = '{1, 0, 0, 0, 0, 0, 30'h17, 3, 1, 0, 30'h15};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 30'h00, 2, 1, 0, 30'h16};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 30'h00, 1, 1, 0, 30'h17};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 30'h00, 0, 0, 0, 30'h00};
        vecs[13] = '{0, 1, 0, 0, 0, 0, 30'h00, 0, 0, 0, 30'h00};

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].fv, vecs[i].ds, vecs[i].kl, vecs[i].fs, vecs[i].fsid,
                  vecs[i].fid, vecs[i].pc, 32'h13);
            tick();
            chk($sformatf("vec%0d_count", i), 32'(iq_count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_valid", i), 32'(iq_valid), 32'(vecs[i].e_val));
            chk($sformatf("vec%0d_stall", i), 32'(iq_stall), 32'(vecs[i].e_stall));
            if (vecs[i].e_val) begin
                chk($sformatf("vec%0d_pc", i), 32'(iq_pc), 32'(vecs[i].e_pc));
                chk($sformatf("vec%0d_exc", i), 32'(iq_exc), 32'(vecs[i].e_pc[0]));
            end
        end

        // Squash specid 1: only the specid-0 head is delivered.
        drive(1, 1, 0, 0, 0, 0, 30'h20, 32'h13); tick();
        drive(1, 1, 0, 0, 0, 1, 30'h21, 32'h13); tick();
        drive(1, 1, 0, 0, 0, 1, 30'h22, 32'h13); tick();
        chk("flush_pre_count", 32'(iq_count), 3);
        drive(1, 1, 0, 1, 1, 1, 30'h23, 32'h13); tick();
        chk("flush_count_hold", 32'(iq_count), 3);
        chk("flush_head_valid", 32'(iq_valid), 1);
        chk("flush_head_pc", 32'(iq_pc), 32'h20);
        chk("flush_head_specid", 32'(iq_specid), 0);
        drive(0, 0, 0, 0, 0, 0, '0, '0); tick();
        chk("flush_dead1_valid", 32'(iq_valid), 0);
        chk("flush_dead1_count", 32'(iq_count), 2);
        tick();
        chk("flush_dead2_valid", 32'(iq_valid), 0);
        chk("flush_dead2_count", 32'(iq_count), 1);
        tick();
        chk("flush_drain_count", 32'(iq_count), 0);
        chk("flush_drain_valid", 32'(iq_valid), 0);

        // Kill with a simultaneous fetch discards everything.
        drive(1, 1, 0, 0, 0, 0, 30'h30, 32'h13); tick();
        drive(1, 1, 0, 0, 0, 0, 30'h31, 32'h13); tick();
        chk("kill_pre_count", 32'(iq_count), 2);
        drive(1, 1, 1, 0, 0, 0, 30'h32, 32'h13); tick();
        chk("kill_count", 32'(iq_count), 0);
        chk("kill_valid", 32'(iq_valid), 0);
        drive(0, 1, 0, 0, 0, 0, '0, '0); tick();
        chk("kill_idle_count", 32'(iq_count), 0);
        drive(1, 1, 0, 0, 0, 0, 30'h33, 32'h13); tick();
        chk("kill_after_count", 32'(iq_count), 1);
        chk("kill_after_pc", 32'(iq_pc), 32'h33);

        // Reset dominates enqueue.
        reset = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 30'h34, 32'h13); tick();
        reset = 1'b0;
        chk("reset_dom_count", 32'(iq_count), 0);
        chk("reset_dom_valid", 32'(iq_valid), 0);

        // Predecode of jal, jalr, branch, addi.
        pd_insn[0] = 32'h0000006F; pd_insn[1] = 32'h00008067;
        pd_insn[2] = 32'h00000063; pd_insn[3] = 32'h00000013;
`ifdef INSN_QUEUE_PREDECODE_EN
        exp_pd[0] = 3'b010; exp_pd[1] = 3'b011; exp_pd[2] = 3'b100; exp_pd[3] = 3'b000;
`else
        exp_pd[0] = 3'b000; exp_pd[1] = 3'b000; exp_pd[2] = 3'b000; exp_pd[3] = 3'b000;
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 0, 30'(32'h40 + i), pd_insn[i]);
            tick();
        end
        chk("pd_fill_count", 32'(iq_count), 4);
        drive(0, 0, 0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pd%0d_insn", i), iq_insn, pd_insn[i]);
            chk($sformatf("pd%0d_bits", i), 32'(iq_pd), 32'(exp_pd[i]));
            tick();
        end
        chk("pd_drain_count", 32'(iq_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
